// File: rtl/ifetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch unit, ack/data from memory.
interface ifetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches over a req/ack bus and forms the next PC on retire.
// Optional performance counters (retired_cnt, fetch_wait_cnt) are enabled by `IFETCH_PERF_CNT_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ifetch_unit_if.master     mem,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              pcsrc,
  input  logic              jump,
  input  logic              jumpr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              stall,
  output logic              fetch_fault
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       fetch_wait_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, ISSUE, FAULT} state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] branch_off;
  logic              retire;
  logic              fetch_done;

  assign pc_plus4      = pc + 32'd4;
  assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign retire        = (state == ISSUE) && !stall;
  assign fetch_done    = (state == FETCH) && mem.imem_ack;
  assign mem.imem_addr = pc;

  // Control-flow priority: register jump, then J-type, then taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (jumpr)
      next_pc = jr_target;
    else if (jump)
      next_pc = {pc_plus4[ADDR_W-1:ADDR_W-4], instr[25:0], 2'b00};
    else if (pcsrc)
      next_pc = pc_plus4 + branch_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= BOOT;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      BOOT:    state_n = FETCH;
      FETCH:   if (mem.imem_ack) state_n = ISSUE;
      ISSUE:   if (!stall) state_n = (next_pc[1:0] != 2'b00) ? FAULT : FETCH;
      FAULT:   state_n = FAULT;
      default: state_n = BOOT;
    endcase
  end

  // Outputs decode straight from state so reset removes imem_req without a clock edge.
  always_comb begin
    mem.imem_req = 1'b0;
    instr_valid  = 1'b0;
    fetch_fault  = 1'b0;
    case (state)
      FETCH:   mem.imem_req = 1'b1;
      ISSUE:   instr_valid  = 1'b1;
      FAULT:   fetch_fault  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      if (fetch_done)
        instr <= mem.imem_rdata;
      if (retire)
        pc <= next_pc;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt    <= 32'h0;
      fetch_wait_cnt <= 32'h0;
    end else begin
      if (retire)
        retired_cnt <= retired_cnt + 32'd1;
      if ((state == FETCH) && !mem.imem_ack)
        fetch_wait_cnt <= fetch_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the MIPS controller/decoder.
- Owns the PC register and fetches from a variable-latency instruction memory over a req/ack handshake.
- Presents the fetched instr word, with instr_valid, to the controller and datapath.
- Consumes the controller's pcsrc/jump/jumpr plus the rs value to form the next PC when an instruction retires.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 32, PC/address width; fixed at 32 for this core.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  32  fetch address; equals pc while imem_req is high.
- imem_ack  input  1  memory response valid; imem_rdata is sampled in that cycle.
- imem_rdata  input  32  instruction word.
- instr  output  32  registered instruction word to the controller and datapath.
- instr_valid  output  1  instr is live and executing this cycle.
- pc  output  32  address of instr.
- pc_plus4  output  32  pc+4, for the link register and the branch base.
- pcsrc  input  1  taken conditional branch, from the controller.
- jump  input  1  J-type jump, from the controller.
- jumpr  input  1  register jump, from the controller.
- jr_target  input  32  rs register value for jumpr.
- stall  input  1  datapath not ready to retire; the instruction is held.
- fetch_fault  output  1  sticky misaligned-target fault.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_fault=0, state=BOOT. imem_req drops combinationally on reset assertion, including mid-handshake. The outstanding response is discarded.
- FSM states: BOOT, FETCH, ISSUE, FAULT.
- BOOT: lasts one cycle after reset release, then goes to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1: instr<=imem_rdata, go to ISSUE.
  - Otherwise remain; there is no timeout.
  - Zero-wait memory (ack in the same cycle as req) gives a fetch latency of 1 cycle.
- ISSUE:
  - instr_valid=1, imem_req=0.
  - stall=1: hold instr and pc unchanged.
  - stall=0: the instruction retires this cycle; pc<=next_pc, go to FETCH. If next_pc[1:0]!=0, go to FAULT instead.
- next_pc priority, sampled only in ISSUE with stall=0:
  - jumpr: jr_target.
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - pcsrc: pc_plus4 + (sign_extend(instr[15:0]) << 2).
  - otherwise: pc_plus4.
  - All arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- Simultaneous control flags are resolved by the priority above; no error is raised.
- pc_plus4 is combinational, pc+4.
- FAULT:
  - fetch_fault=1, instr_valid=0, imem_req=0.
  - pc holds the faulting target.
  - Only reset exits this state.
- imem_ack outside FETCH is ignored.
- Retired-instruction throughput is 1 per (fetch latency + 1) cycles minimum.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- With the macro defined, two extra outputs:
  - retired_cnt[31:0]: increments on each ISSUE cycle with stall=0.
  - fetch_wait_cnt[31:0]: increments on each FETCH cycle with imem_ack=0.
  - Both clear on reset and wrap at 2^32.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then ack in the same cycle each fetch, no control flow: imem_addr sequence 0,4,8,C; instr_valid pulses every other cycle; pc matches each instr.
- imem_ack delayed 3 cycles: imem_req/addr held stable 4 cycles; instr captures rdata only on the ack cycle.
- At pc=0x40, instr=0x1000FFFF with pcsrc=1: next fetch at 0x40.
  - Same pc with jump=1 and instr[25:0]=0x0000100: next fetch at 0x400.
  - jumpr=1 with jr_target=0x88 and jump=1 together: next fetch at 0x88.
- stall=1 for 5 cycles in ISSUE: instr, pc, instr_valid unchanged; no imem_req; retires on stall release.
- jumpr with jr_target=0x102: fetch_fault=1, no further imem_req; rst_n pulse clears it and fetch restarts at RESET_PC.
- rst_n asserted mid-FETCH while imem_req=1: imem_req falls without waiting for clk. A late ack after reset release but before BOOT exits is ignored.
